instr_fetch_unit: RTL and testbench

Instruction supply side of the multicycle CPU: fetches instructions from instruction memory over a req/ack handshake, buffers up to two prefetched words, and hands one instruction word per request to the control unit. It sits between instruction memory and the control unit's IR input. It holds IR stable for the whole multicycle execution of that instruction and redirects fetch on taken branches.

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: req/ack fetch from instruction memory into a two-entry
// prefetch queue, issues one word per fetch_req into IR, redirects on branches.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_req,
   input  logic        branch_valid,
   input  logic [31:0] branch_target,
   output logic [31:0] IR,
   output logic [31:0] pc_out,
   output logic        ir_issue,
   output logic        fetch_stall,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   // state  | meaning
   // S_IDLE | no request outstanding; launch one if the queue has room
   // S_WAIT | request outstanding, data will be queued on ack
   // S_DROP | request outstanding but made stale by a branch; data discarded on ack
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [1:0]  cnt_q, cnt_d, cnt_mid;
   logic [31:0] q0_addr_q, q0_addr_d, q0_data_q, q0_data_d;
   logic [31:0] q1_addr_q, q1_addr_d, q1_data_q, q1_data_d;
   logic [31:0] ir_q, ir_d, pc_q, pc_d, addr_q, addr_d;
   logic        issue_q, issue_d, req_q, req_d;
   logic        do_pop, do_push;

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_d      = req_q;
      addr_d     = addr_q;
      do_push    = 1'b0;
      do_pop     = fetch_req && (cnt_q != 2'd0) && !branch_valid;

      case (state_q)
         S_IDLE: begin
            if ((cnt_q != 2'd2) && !branch_valid) begin
               req_d   = 1'b1;
               addr_d  = fetch_pc_q;
               state_d = S_WAIT;
            end else begin
               req_d = 1'b0;
            end
         end
         S_WAIT: begin
            if (branch_valid) begin
               if (mem_ack) begin
                  req_d   = 1'b0;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DROP;
               end
            end else if (mem_ack) begin
               do_push    = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               req_d      = 1'b0;
               state_d    = S_IDLE;
            end
         end
         S_DROP: begin
            // the stale request is never withdrawn; wait out its ack
            if (mem_ack) begin
               req_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = S_IDLE;
         end
      endcase

      if (branch_valid) fetch_pc_d = {branch_target[31:2], 2'b00};

      q0_addr_d = q0_addr_q;
      q0_data_d = q0_data_q;
      q1_addr_d = q1_addr_q;
      q1_data_d = q1_data_q;
      cnt_mid   = cnt_q;
      if (do_pop) begin
         q0_addr_d = q1_addr_q;
         q0_data_d = q1_data_q;
         cnt_mid   = cnt_q - 2'd1;
      end
      cnt_d = cnt_mid;
      if (do_push) begin
         if (cnt_mid == 2'd0) begin
            q0_addr_d = addr_q;
            q0_data_d = mem_rdata;
         end else begin
            q1_addr_d = addr_q;
            q1_data_d = mem_rdata;
         end
         cnt_d = cnt_mid + 2'd1;
      end
      if (branch_valid) cnt_d = 2'd0;

      ir_d    = ir_q;
      pc_d    = pc_q;
      issue_d = 1'b0;
      if (do_pop) begin
         ir_d    = q0_data_q;
         pc_d    = q0_addr_q;
         issue_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         cnt_q      <= 2'd0;
         q0_addr_q  <= 32'd0;
         q0_data_q  <= 32'd0;
         q1_addr_q  <= 32'd0;
         q1_data_q  <= 32'd0;
         ir_q       <= 32'd0;
         pc_q       <= 32'd0;
         issue_q    <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= 32'd0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         cnt_q      <= cnt_d;
         q0_addr_q  <= q0_addr_d;
         q0_data_q  <= q0_data_d;
         q1_addr_q  <= q1_addr_d;
         q1_data_q  <= q1_data_d;
         ir_q       <= ir_d;
         pc_q       <= pc_d;
         issue_q    <= issue_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
      end
   end

   assign IR          = ir_q;
   assign pc_out      = pc_q;
   assign ir_issue    = issue_q;
   assign mem_req     = req_q;
   assign mem_addr    = addr_q;
   assign fetch_stall = fetch_req && (cnt_q == 2'd0) && !branch_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: behavioural instruction memory returning
// addr ^ A5A5_0000 with programmable latency, plus a second instance for PC wrap.
module tb_instr_fetch_unit;

   localparam logic [31:0] MAGIC = 32'hA5A5_0000;

   logic        clock, reset, reset_w;
   logic        fetch_req, branch_valid;
   logic [31:0] branch_target;
   logic [31:0] IR, pc_out, mem_addr, mem_rdata;
   logic        ir_issue, fetch_stall, mem_req, mem_ack;

   logic [31:0] ir_w, pc_out_w, mem_addr_w, mem_rdata_w;
   logic        ir_issue_w, fetch_stall_w, mem_req_w, mem_ack_w;

   int checks = 0;
   int errors = 0;
   int mem_lat = 0;
   int wait_cnt = 0;
   int req_count = 0;
   int issue_count = 0;
   int wn = 0;
   logic req_prev = 1'b0;
   logic req_prev_w = 1'b0;
   logic [31:0] mlog [0:15];
   logic [31:0] wlog [0:15];
   logic found;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clock(clock), .reset(reset), .fetch_req(fetch_req),
      .branch_valid(branch_valid), .branch_target(branch_target),
      .IR(IR), .pc_out(pc_out), .ir_issue(ir_issue), .fetch_stall(fetch_stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clock(clock), .reset(reset_w), .fetch_req(1'b1),
      .branch_valid(1'b0), .branch_target(32'h0),
      .IR(ir_w), .pc_out(pc_out_w), .ir_issue(ir_issue_w), .fetch_stall(fetch_stall_w),
      .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      mem_ack = 1'b0;
      mem_rdata = 32'h0;
      mem_ack_w = 1'b0;
      mem_rdata_w = 32'h0;
   end

   // Memory models: ack is set up on the falling edge so the DUT samples it on the next rise.
   always @(negedge clock) begin
      if (mem_req) begin
         if (!req_prev) begin
            if (req_count < 16) mlog[req_count] = mem_addr;
            req_count++;
         end
         if (wait_cnt == mem_lat) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_addr ^ MAGIC;
         end else begin
            wait_cnt++;
            mem_ack = 1'b0;
         end
      end else begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end
      req_prev = mem_req;
      if (ir_issue) issue_count++;

      if (mem_req_w) begin
         if (!req_prev_w) begin
            if (wn < 16) wlog[wn] = mem_addr_w;
            wn++;
         end
         mem_ack_w   = 1'b1;
         mem_rdata_w = mem_addr_w ^ MAGIC;
      end else begin
         mem_ack_w = 1'b0;
      end
      req_prev_w = mem_req_w;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      reset_w = 1'b0;
      fetch_req = 1'b0;
      branch_valid = 1'b0;
      branch_target = 32'h0;
      found = 1'b0;
      repeat (2) step();
      chk("rst_IR", IR, 32'h0);
      chk("rst_pc_out", pc_out, 32'h0);
      chk("rst_ir_issue", {31'h0, ir_issue}, 32'h0);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);

      reset = 1'b1;
      reset_w = 1'b1;
      step();
      chk("first_req", {31'h0, mem_req}, 32'h1);
      chk("first_addr", mem_addr, 32'h0);

      // queue fills with two words and fetching stops
      repeat (10) step();
      chk("full_req_count", req_count, 32'd2);
      chk("full_req_low", {31'h0, mem_req}, 32'h0);
      chk("full_second_addr", mlog[1], 32'h4);

      fetch_req = 1'b1;
      #1;
      chk("full_no_stall", {31'h0, fetch_stall}, 32'h0);
      step();
      fetch_req = 1'b0;
      chk("iss0_pulse", {31'h0, ir_issue}, 32'h1);
      chk("iss0_IR", IR, 32'hA5A5_0000);
      chk("iss0_pc", pc_out, 32'h0);
      step();
      chk("refill_req", {31'h0, mem_req}, 32'h1);
      chk("refill_addr", mem_addr, 32'h8);
      repeat (3) step();

      for (int k = 0; k < 3; k++) begin
         fetch_req = 1'b1;
         step();
         fetch_req = 1'b0;
         chk("seq_pulse", {31'h0, ir_issue}, 32'h1);
         chk("seq_IR", IR, MAGIC ^ (32'h4 + 32'(4 * k)));
         chk("seq_pc", pc_out, 32'h4 + 32'(4 * k));
         repeat (3) step();
      end
      chk("seq_issue_count", issue_count, 32'd4);

      // branch and fetch_req together with a full queue
      fetch_req = 1'b1;
      branch_valid = 1'b1;
      branch_target = 32'h0000_2000;
      #1;
      chk("brf_no_stall", {31'h0, fetch_stall}, 32'h0);
      step();
      branch_valid = 1'b0;
      chk("brf_no_issue", {31'h0, ir_issue}, 32'h0);
      chk("brf_IR_held", IR, 32'hA5A5_000C);
      chk("brf_pc_held", pc_out, 32'hC);
      chk("brf_req_low", {31'h0, mem_req}, 32'h0);
      #1;
      chk("brf_flushed_stall", {31'h0, fetch_stall}, 32'h1);
      step();
      chk("brf_req", {31'h0, mem_req}, 32'h1);
      chk("brf_addr", mem_addr, 32'h2000);
      step();
      step();
      chk("brf_issue_pulse", {31'h0, ir_issue}, 32'h1);
      chk("brf_issue_IR", IR, 32'hA5A5_2000);
      chk("brf_issue_pc", pc_out, 32'h2000);
      fetch_req = 1'b0;
      repeat (5) step();

      // branch while a slow request is outstanding
      mem_lat = 3;
      fetch_req = 1'b1;
      step();
      fetch_req = 1'b0;
      chk("pre_drop_IR", IR, 32'hA5A5_2004);
      step();
      chk("wait_req", {31'h0, mem_req}, 32'h1);
      chk("wait_addr", mem_addr, 32'h200C);
      branch_valid = 1'b1;
      branch_target = 32'h0000_1003;
      step();
      branch_valid = 1'b0;
      chk("drop_req_held", {31'h0, mem_req}, 32'h1);
      chk("drop_addr_held", mem_addr, 32'h200C);
      fetch_req = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (mem_req && mem_addr != 32'h200C) found = 1'b1;
      end
      chk("redirect_seen", {31'h0, found}, 32'h1);
      chk("redirect_addr", mem_addr, 32'h1000);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (ir_issue) found = 1'b1;
      end
      fetch_req = 1'b0;
      chk("redirect_issue_seen", {31'h0, found}, 32'h1);
      chk("redirect_IR", IR, 32'hA5A5_1000);
      chk("redirect_pc", pc_out, 32'h1000);
      chk("total_issue_count", issue_count, 32'd7);

      // asynchronous reset between edges during an outstanding request
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         if (mem_req) found = 1'b1;
      end
      chk("areset_req_seen", {31'h0, found}, 32'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("areset_req", {31'h0, mem_req}, 32'h0);
      chk("areset_IR", IR, 32'h0);
      chk("areset_issue", {31'h0, ir_issue}, 32'h0);
      chk("areset_pc", pc_out, 32'h0);
      step();
      step();
      reset = 1'b1;
      step();
      chk("restart_req", {31'h0, mem_req}, 32'h1);
      chk("restart_addr", mem_addr, 32'h0);

      chk("wrap_count", {31'h0, wn >= 3}, 32'h1);
      chk("wrap_addr0", wlog[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", wlog[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", wlog[2], 32'h0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
